// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, constants and state encoding for instruction fetch
package inst_fetch_pkg;

  localparam int IDWidth          = 32;
  localparam int AddressWidth     = 32;
  localparam logic [IDWidth-1:0] NOP = 32'h0000_0013;
  localparam int ICacheIndexWidth = 6;
  localparam int ICacheEntries    = 1 << ICacheIndexWidth;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_MISS = 1'b1
  } if_state_e;

  // Memory requests are always for whole words.
  function automatic logic [AddressWidth-1:0] word_align(input logic [AddressWidth-1:0] addr);
    return {addr[AddressWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// rtl/inst_fetch_icache.sv - direct-mapped one-word-per-line instruction cache arrays
module icache
  import inst_fetch_pkg::*;
#(
  parameter int Entries    = ICacheEntries,
  parameter int IndexWidth = ICacheIndexWidth,
  parameter int TagWidth   = AddressWidth - ICacheIndexWidth - 2,
  parameter int DataWidth  = IDWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IndexWidth-1:0] rd_index_i,
  input  logic [TagWidth-1:0]   rd_tag_i,
  output logic                  hit_o,
  output logic [DataWidth-1:0]  rd_data_o,
  input  logic                  wr_en_i,
  input  logic [IndexWidth-1:0] wr_index_i,
  input  logic [TagWidth-1:0]   wr_tag_i,
  input  logic [DataWidth-1:0]  wr_data_i
);

  logic [Entries-1:0]   valid_q;
  logic [TagWidth-1:0]  tag_q  [Entries];
  logic [DataWidth-1:0] data_q [Entries];

  assign hit_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_index_i];

  // Valid bits are only ever cleared by reset; a refill sets one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data storage need no reset because valid gates every hit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch PC, redirect mux and miss FSM feeding the instruction queue
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ICacheEntries = inst_fetch_pkg::ICacheEntries,
  parameter int IndexWidth    = ICacheIndexWidth
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    mc_if_rdy_in,
  input  logic [IDWidth-1:0]      mc_if_data_in,
  output logic                    if_mc_en_out,
  output logic [AddressWidth-1:0] if_mc_addr_out,
  input  logic                    instqueue_if_full_in,
  output logic                    if_instqueue_en_out,
  output logic [IDWidth-1:0]      if_instqueue_inst_out,
  output logic [AddressWidth-1:0] if_instqueue_pc_out,
  input  logic                    rob_if_rst_in,
  input  logic [AddressWidth-1:0] rob_if_pc_in,
  input  logic                    bp_if_rst_in,
  input  logic [AddressWidth-1:0] bp_if_pc_in,
  input  logic                    decoder_if_rst_in,
  input  logic [AddressWidth-1:0] decoder_if_pc_in
);

  localparam int TagWidth = AddressWidth - IndexWidth - 2;

  if_state_e               state_q;
  logic [AddressWidth-1:0] pc_q;
  logic                    mc_en_q;
  logic [AddressWidth-1:0] mc_addr_q;
  logic                    push_en_q;
  logic [IDWidth-1:0]      push_inst_q;
  logic [AddressWidth-1:0] push_pc_q;

  logic                    hit;
  logic [IDWidth-1:0]      hit_data;
  logic                    redirect;
  logic [AddressWidth-1:0] redirect_pc;
  logic                    refill_we;

  // The refill always lands at the originally requested address, even after a redirect.
  assign refill_we = rdy_in && (state_q == IF_MISS) && mc_if_rdy_in;

  icache #(
    .Entries   (ICacheEntries),
    .IndexWidth(IndexWidth),
    .TagWidth  (TagWidth),
    .DataWidth (IDWidth)
  ) u_icache (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .rd_index_i(pc_q[IndexWidth+1:2]),
    .rd_tag_i  (pc_q[AddressWidth-1:IndexWidth+2]),
    .hit_o     (hit),
    .rd_data_o (hit_data),
    .wr_en_i   (refill_we),
    .wr_index_i(mc_addr_q[IndexWidth+1:2]),
    .wr_tag_i  (mc_addr_q[AddressWidth-1:IndexWidth+2]),
    .wr_data_i (mc_if_data_in)
  );

  // Redirect source select: ROB over branch predictor over decoder.
  always_comb begin
    redirect    = rob_if_rst_in | bp_if_rst_in | decoder_if_rst_in;
    redirect_pc = decoder_if_pc_in;
    if (rob_if_rst_in) begin
      redirect_pc = rob_if_pc_in;
    end else if (bp_if_rst_in) begin
      redirect_pc = bp_if_pc_in;
    end
  end

  // Fetch FSM: PC update, queue push and memory request, all frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IF_IDLE;
      pc_q        <= '0;
      mc_en_q     <= 1'b0;
      mc_addr_q   <= '0;
      push_en_q   <= 1'b0;
      push_inst_q <= NOP;
      push_pc_q   <= '0;
    end else if (rdy_in) begin
      push_en_q <= 1'b0;
      if (redirect) begin
        pc_q <= redirect_pc;
      end
      case (state_q)
        IF_IDLE: begin
          if (!redirect) begin
            if (hit && !instqueue_if_full_in) begin
              push_en_q   <= 1'b1;
              push_inst_q <= hit_data;
              push_pc_q   <= pc_q;
              pc_q        <= pc_q + AddressWidth'(4);
            end else if (!hit) begin
              mc_en_q   <= 1'b1;
              mc_addr_q <= word_align(pc_q);
              state_q   <= IF_MISS;
            end
          end
        end
        IF_MISS: begin
          if (mc_if_rdy_in) begin
            mc_en_q <= 1'b0;
            state_q <= IF_IDLE;
          end
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end

  assign if_mc_en_out          = mc_en_q;
  assign if_mc_addr_out        = mc_addr_q;
  assign if_instqueue_en_out   = push_en_q;
  assign if_instqueue_inst_out = push_inst_q;
  assign if_instqueue_pc_out   = push_pc_q;

endmodule
